// File: rtl/simple_alu_issue_arbiter.sv
// rtl/simple_alu_issue_arbiter.sv - round-robin issue arbiter sharing one combinational ALU, with a single-entry writeback register
module simple_alu_issue_arbiter #(
  parameter int DATABITWIDTH = 16,
  parameter int REQUESTERS   = 4,
  parameter int TAGBITWIDTH  = 4,
  localparam int IDXW        = (REQUESTERS > 1) ? $clog2(REQUESTERS) : 1
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic [REQUESTERS-1:0]              ReqValid,
  output logic [REQUESTERS-1:0]              ReqReady,
  input  logic [4*REQUESTERS-1:0]            ReqMinorOpcode,
  input  logic [DATABITWIDTH*REQUESTERS-1:0] ReqOperandA,
  input  logic [DATABITWIDTH*REQUESTERS-1:0] ReqOperandB,
  input  logic [TAGBITWIDTH*REQUESTERS-1:0]  ReqTag,
  output logic [3:0]                         AluMinorOpcode,
  output logic [DATABITWIDTH-1:0]            AluOperandA,
  output logic [DATABITWIDTH-1:0]            AluOperandB,
  input  logic [DATABITWIDTH-1:0]            AluResult,
  input  logic                               Flush,
  output logic                               WbValid,
  input  logic                               WbReady,
  output logic [DATABITWIDTH-1:0]            WbData,
  output logic [TAGBITWIDTH-1:0]             WbTag,
  output logic [IDXW-1:0]                    WbRequester
);

  logic [IDXW-1:0]         priority_q, priority_d;
  logic                    wb_valid_q;
  logic [DATABITWIDTH-1:0] wb_data_q;
  logic [TAGBITWIDTH-1:0]  wb_tag_q;
  logic [IDXW-1:0]         wb_req_q;

  logic                    grant_any;
  logic [IDXW-1:0]         grant_idx;
  logic [REQUESTERS-1:0]   grant;
  logic [TAGBITWIDTH-1:0]  grant_tag;
  logic                    accept_enable;
  logic                    accept;

  // Scan starts at the priority pointer; the sum is one bit wider so the wrap
  // works for non-power-of-two requester counts. Reset suppresses all grants.
  always_comb begin
    logic [IDXW:0]   sum;
    logic [IDXW-1:0] cand;
    grant_any = 1'b0;
    grant_idx = '0;
    sum       = '0;
    cand      = '0;
    for (int k = 0; k < REQUESTERS; k++) begin
      sum = {1'b0, priority_q} + (IDXW+1)'(k);
      if (sum >= (IDXW+1)'(REQUESTERS)) begin
        sum = sum - (IDXW+1)'(REQUESTERS);
      end
      cand = sum[IDXW-1:0];
      if (!grant_any && ReqValid[cand] && rst_n) begin
        grant_any = 1'b1;
        grant_idx = cand;
      end
    end
  end

  always_comb begin
    grant          = '0;
    AluMinorOpcode = '0;
    AluOperandA    = '0;
    AluOperandB    = '0;
    grant_tag      = '0;
    for (int i = 0; i < REQUESTERS; i++) begin
      if (grant_any && (grant_idx == IDXW'(i))) begin
        grant[i]       = 1'b1;
        AluMinorOpcode = ReqMinorOpcode[i*4 +: 4];
        AluOperandA    = ReqOperandA[i*DATABITWIDTH +: DATABITWIDTH];
        AluOperandB    = ReqOperandB[i*DATABITWIDTH +: DATABITWIDTH];
        grant_tag      = ReqTag[i*TAGBITWIDTH +: TAGBITWIDTH];
      end
    end
  end

  assign accept_enable = ~Flush & (~wb_valid_q | WbReady);
  assign ReqReady      = grant & {REQUESTERS{accept_enable}};
  assign accept        = grant_any & accept_enable;
  assign priority_d    = (grant_idx == IDXW'(REQUESTERS-1)) ? '0 : grant_idx + 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      priority_q <= '0;
      wb_valid_q <= 1'b0;
      wb_data_q  <= '0;
      wb_tag_q   <= '0;
      wb_req_q   <= '0;
    end else if (accept) begin
      priority_q <= priority_d;
      wb_valid_q <= 1'b1;
      wb_data_q  <= AluResult;
      wb_tag_q   <= grant_tag;
      wb_req_q   <= grant_idx;
    end else if (Flush || WbReady) begin
      wb_valid_q <= 1'b0;
    end
  end

  assign WbValid     = wb_valid_q;
  assign WbData      = wb_data_q;
  assign WbTag       = wb_tag_q;
  assign WbRequester = wb_req_q;

endmodule

// File: tb/tb_simple_alu_issue_arbiter.sv
// tb/tb_simple_alu_issue_arbiter.sv - directed and random checks of the issue arbiter against a behavioural model
module tb_simple_alu_issue_arbiter;
  localparam int R  = 4;
  localparam int DW = 16;
  localparam int TW = 4;
  localparam int IW = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n;
  logic [R-1:0]  ReqValid, ReqReady;
  logic [4*R-1:0]  ReqMinorOpcode;
  logic [DW*R-1:0] ReqOperandA, ReqOperandB;
  logic [TW*R-1:0] ReqTag;
  logic [3:0]    AluMinorOpcode;
  logic [DW-1:0] AluOperandA, AluOperandB, AluResult;
  logic          Flush, WbValid, WbReady;
  logic [DW-1:0] WbData;
  logic [TW-1:0] WbTag;
  logic [IW-1:0] WbRequester;

  simple_alu_issue_arbiter #(.DATABITWIDTH(DW), .REQUESTERS(R), .TAGBITWIDTH(TW)) dut (
    .clk(clk), .rst_n(rst_n), .ReqValid(ReqValid), .ReqReady(ReqReady),
    .ReqMinorOpcode(ReqMinorOpcode), .ReqOperandA(ReqOperandA), .ReqOperandB(ReqOperandB),
    .ReqTag(ReqTag), .AluMinorOpcode(AluMinorOpcode), .AluOperandA(AluOperandA),
    .AluOperandB(AluOperandB), .AluResult(AluResult), .Flush(Flush), .WbValid(WbValid),
    .WbReady(WbReady), .WbData(WbData), .WbTag(WbTag), .WbRequester(WbRequester)
  );

  function automatic logic [DW-1:0] alu(input logic [3:0] o, input logic [DW-1:0] x, input logic [DW-1:0] y);
    case (o)
      4'h0: return x | (DW'(1) << y[3:0]);
      4'h1: return x + y;
      4'h2: return x - y;
      4'h3: return x & y;
      4'h4: return x | y;
      4'h5: return x ^ y;
      4'h6: return x >> y[3:0];
      4'h7: return x << y[3:0];
      default: return ~x;
    endcase
  endfunction

  always_comb AluResult = alu(AluMinorOpcode, AluOperandA, AluOperandB);

  int vectors = 0;
  int miscompares = 0;

  int            prio;
  bit            m_valid;
  logic [DW-1:0] m_data;
  logic [TW-1:0] m_tag;
  int            m_req;

  logic [R-1:0]  rv;
  logic [3:0]    op [R];
  logic [DW-1:0] oa [R];
  logic [DW-1:0] ob [R];
  logic [TW-1:0] tg [R];
  logic          fl, wr;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    prio = 0; m_valid = 0; m_data = '0; m_tag = '0; m_req = 0;
  endtask

  task automatic drive();
    for (int i = 0; i < R; i++) begin
      ReqMinorOpcode[4*i +: 4] = op[i];
      ReqOperandA[DW*i +: DW]  = oa[i];
      ReqOperandB[DW*i +: DW]  = ob[i];
      ReqTag[TW*i +: TW]       = tg[i];
    end
    ReqValid = rv; Flush = fl; WbReady = wr;
  endtask

  task automatic rnd_payload();
    for (int i = 0; i < R; i++) begin
      op[i] = 4'($urandom_range(0, 9));
      oa[i] = DW'($urandom);
      ob[i] = DW'($urandom);
      tg[i] = TW'($urandom);
    end
  endtask

  task automatic chk_reset_outputs();
    chk("rst_ready", 32'(ReqReady), 0);
    chk("rst_wbvalid", 32'(WbValid), 0);
    chk("rst_wbdata", 32'(WbData), 0);
    chk("rst_wbtag", 32'(WbTag), 0);
    chk("rst_wbreq", 32'(WbRequester), 0);
    chk("rst_aluop", 32'(AluMinorOpcode), 0);
    chk("rst_alua", 32'(AluOperandA), 0);
  endtask

  // One cycle: drive, check every output against the model, clock, advance the model.
  task automatic step();
    int g;
    bit en;
    drive();
    #1;
    g = -1;
    for (int k = 0; k < R; k++) begin
      int idx;
      idx = (prio + k) % R;
      if (g < 0 && rv[idx]) g = idx;
    end
    en = !fl && (!m_valid || wr);
    chk("req_ready", 32'(ReqReady), (g >= 0 && en) ? (32'd1 << g) : 32'd0);
    chk("alu_op", 32'(AluMinorOpcode), (g >= 0) ? 32'(op[g]) : 32'd0);
    chk("alu_a", 32'(AluOperandA), (g >= 0) ? 32'(oa[g]) : 32'd0);
    chk("alu_b", 32'(AluOperandB), (g >= 0) ? 32'(ob[g]) : 32'd0);
    chk("wb_valid", 32'(WbValid), 32'(m_valid));
    chk("wb_data", 32'(WbData), 32'(m_data));
    chk("wb_tag", 32'(WbTag), 32'(m_tag));
    chk("wb_req", 32'(WbRequester), 32'(m_req));
    @(posedge clk);
    if (g >= 0 && en) begin
      m_valid = 1;
      m_data  = alu(op[g], oa[g], ob[g]);
      m_tag   = tg[g];
      m_req   = g;
      prio    = (g + 1) % R;
    end else if (fl || wr) begin
      m_valid = 0;
    end
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0;
    rnd_payload();
    rv = '1; fl = 0; wr = 1;
    drive();
    #3;
    chk_reset_outputs();
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();

    // Single op on port 2: bit set of bit 3 in 0x0010
    rnd_payload();
    rv = 4'b0100; op[2] = 4'h0; oa[2] = 16'h0010; ob[2] = 16'd3; tg[2] = 4'd5; wr = 1;
    step();
    rv = 4'b0000;
    drive(); #1;
    chk("single_data", 32'(WbData), 32'h0018);
    chk("single_req", 32'(WbRequester), 2);
    step();
    rv = 4'b1111;
    drive(); #1;
    chk("single_next_grant", 32'(ReqReady), 32'b1000);
    step();

    // Round-robin with everything valid
    for (int c = 0; c < 6; c++) begin
      rnd_payload(); rv = 4'b1111; wr = 1;
      step();
    end

    // Backpressure: shift-left result held while port 1 waits
    rnd_payload();
    rv = 4'b0001; op[0] = 4'h7; oa[0] = 16'h0001; ob[0] = 16'd4; wr = 1;
    step();
    rv = 4'b0010; wr = 0;
    for (int c = 0; c < 3; c++) begin
      drive(); #1;
      chk("bp_hold_data", 32'(WbData), 32'h0010);
      step();
    end
    wr = 1;
    drive(); #1;
    chk("bp_release", 32'(ReqReady), 32'b0010);
    step();

    // Flush while holding a result under backpressure
    rv = 4'b1000; fl = 1; wr = 0;
    step();
    fl = 0; rv = 4'b0000; wr = 0;
    step();

    // Random traffic
    for (int c = 0; c < 400; c++) begin
      rnd_payload();
      rv = R'($urandom);
      fl = ($urandom_range(0, 9) == 0);
      wr = ($urandom_range(0, 3) != 0);
      step();
    end

    // Async reset with a result held
    fl = 0; wr = 1; rv = 4'b1111;
    step();
    rv = 4'b0110; wr = 0;
    drive();
    #2;
    rst_n = 1'b0;
    #1;
    chk_reset_outputs();
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    drive(); #1;
    chk("post_reset_grant", 32'(ReqReady), 32'b0010);
    step();
    for (int c = 0; c < 20; c++) begin
      rnd_payload();
      rv = R'($urandom);
      fl = ($urandom_range(0, 7) == 0);
      wr = ($urandom_range(0, 2) != 0);
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
